// File: rtl/enable_table_loader.sv
// Sequencer that copies one 128-byte configuration image from the config
// store into the 512 x 2-bit address-decode enable table, LSB pair first,
// holding the CPU until a complete table has been written.
module enable_table_loader #(
    parameter int CONFIG_BITS     = 4,
    parameter int TABLE_ADDR_BITS = 9,
    parameter bit AUTO_START      = 1'b1
) (
    input  logic                       fpga_clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CONFIG_BITS-1:0]     config_sel,
    output logic [CONFIG_BITS+6:0]     src_addr,
    output logic                       src_re,
    input  logic [7:0]                 src_data,
    output logic                       table_we,
    output logic [1:0]                 table_val,
    output logic [TABLE_ADDR_BITS-1:0] table_write_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [CONFIG_BITS-1:0]       cfg_q, cfg_d;
    logic [6:0]                   idx_q, idx_d;
    logic [1:0]                   pair_q, pair_d;
    logic [7:0]                   shift_q, shift_d;
    logic                         auto_q, auto_d;

    logic [CONFIG_BITS+6:0]       src_addr_d;
    logic                         src_re_d;
    logic                         table_we_d;
    logic [1:0]                   table_val_d;
    logic [TABLE_ADDR_BITS-1:0]   table_write_addr_d;
    logic                         busy_d;
    logic                         done_d;
    logic                         cpu_hold_d;

    // Next-state and next-output decode; outputs are computed one state
    // ahead so every port comes straight from a flop.
    always_comb begin
        state_d            = state_q;
        cfg_d              = cfg_q;
        idx_d              = idx_q;
        pair_d             = pair_q;
        shift_d            = shift_q;
        auto_d             = auto_q;
        src_addr_d         = src_addr;
        src_re_d           = 1'b0;
        table_we_d         = 1'b0;
        table_val_d        = table_val;
        table_write_addr_d = table_write_addr;
        busy_d             = busy;
        done_d             = 1'b0;
        cpu_hold_d         = cpu_hold;

        unique case (state_q)
            S_IDLE: begin
                // auto-start only applies to the first idle cycle after reset
                auto_d = 1'b0;
                if (start || auto_q) begin
                    cfg_d      = config_sel;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    cpu_hold_d = 1'b1;
                    src_re_d   = 1'b1;
                    src_addr_d = {config_sel, 7'd0};
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // first pair goes out directly; the rest is shifted down
                shift_d            = {2'b00, src_data[7:2]};
                table_we_d         = 1'b1;
                table_val_d        = src_data[1:0];
                table_write_addr_d = TABLE_ADDR_BITS'({idx_q, 2'd0});
                pair_d             = 2'd0;
                state_d            = S_WRITE;
            end
            S_WRITE: begin
                if (pair_q == 2'd3) begin
                    if (idx_q == 7'd127) begin
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        cpu_hold_d = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        idx_d      = idx_q + 7'd1;
                        src_re_d   = 1'b1;
                        src_addr_d = {cfg_q, idx_q + 7'd1};
                        state_d    = S_FETCH;
                    end
                end else begin
                    table_we_d         = 1'b1;
                    table_val_d        = shift_q[1:0];
                    shift_d            = {2'b00, shift_q[7:2]};
                    pair_d             = pair_q + 2'd1;
                    table_write_addr_d = TABLE_ADDR_BITS'({idx_q, pair_q + 2'd1});
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            cfg_q            <= '0;
            idx_q            <= '0;
            pair_q           <= '0;
            shift_q          <= '0;
            auto_q           <= AUTO_START;
            src_addr         <= '0;
            src_re           <= 1'b0;
            table_we         <= 1'b0;
            table_val        <= '0;
            table_write_addr <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            cpu_hold         <= 1'b1;
        end else begin
            state_q          <= state_d;
            cfg_q            <= cfg_d;
            idx_q            <= idx_d;
            pair_q           <= pair_d;
            shift_q          <= shift_d;
            auto_q           <= auto_d;
            src_addr         <= src_addr_d;
            src_re           <= src_re_d;
            table_we         <= table_we_d;
            table_val        <= table_val_d;
            table_write_addr <= table_write_addr_d;
            busy             <= busy_d;
            done             <= done_d;
            cpu_hold         <= cpu_hold_d;
        end
    end

endmodule

// File: tb/tb_enable_table_loader.sv
// Bench for enable_table_loader: one instance with manual start, one with
// auto-start, a shared config-store image and a write scoreboard.
module tb_enable_table_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, src_re_a, we_a, busy_a, done_a, hold_a;
    logic [3:0]  sel_a;
    logic [10:0] src_addr_a;
    logic [7:0]  src_data_a;
    logic [1:0]  val_a;
    logic [8:0]  waddr_a;

    logic        rst_b, start_b, src_re_b, we_b, busy_b, done_b, hold_b;
    logic [3:0]  sel_b;
    logic [10:0] src_addr_b;
    logic [7:0]  src_data_b;
    logic [1:0]  val_b;
    logic [8:0]  waddr_b;

    logic [7:0] mem [0:2047];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [8:0] addr;
        logic [1:0] val;
    } wr_t;
    wr_t exp_q[$];

    int         a_writes = 0;
    int         a_dones  = 0;
    int         a_fetch  = 0;
    logic [3:0] a_cfg    = 4'd0;
    int         b_writes = 0;
    int         b_dones  = 0;
    logic [3:0] b_cfg    = 4'd0;

    enable_table_loader #(.CONFIG_BITS(4), .TABLE_ADDR_BITS(9), .AUTO_START(1'b0)) dut_a (
        .fpga_clk(clk), .reset(rst_a), .start(start_a), .config_sel(sel_a),
        .src_addr(src_addr_a), .src_re(src_re_a), .src_data(src_data_a),
        .table_we(we_a), .table_val(val_a), .table_write_addr(waddr_a),
        .busy(busy_a), .done(done_a), .cpu_hold(hold_a)
    );

    enable_table_loader #(.CONFIG_BITS(4), .TABLE_ADDR_BITS(9), .AUTO_START(1'b1)) dut_b (
        .fpga_clk(clk), .reset(rst_b), .start(start_b), .config_sel(sel_b),
        .src_addr(src_addr_b), .src_re(src_re_b), .src_data(src_data_b),
        .table_we(we_b), .table_val(val_b), .table_write_addr(waddr_b),
        .busy(busy_b), .done(done_b), .cpu_hold(hold_b)
    );

    // synchronous block-RAM config store, one read port per loader
    always @(posedge clk) begin
        if (src_re_a) src_data_a <= mem[src_addr_a];
        if (src_re_b) src_data_b <= mem[src_addr_b];
    end

    function automatic logic [1:0] entry(input logic [3:0] cfg, input int k);
        logic [8:0] kk;
        logic [7:0] b;
        kk = k[8:0];
        b  = mem[{cfg, kk[8:2]}];
        b  = b >> {kk[1:0], 1'b0};
        return b[1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_load(input logic [3:0] cfg);
        wr_t e;
        for (int k = 0; k < 512; k++) begin
            e.addr = k[8:0];
            e.val  = entry(cfg, k);
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // monitor A: every table write must match the next scoreboard entry
    always @(negedge clk) begin
        wr_t e;
        if (!rst_a) begin
            if (we_a) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a_write_unexpected: got write addr %0d expected none", waddr_a);
                end else begin
                    e = exp_q.pop_front();
                    check("a_write", {21'd0, waddr_a, val_a}, {21'd0, e.addr, e.val});
                end
                a_writes++;
            end
            if (src_re_a) begin
                check("a_fetch_addr", {21'd0, src_addr_a}, {21'd0, a_cfg, 7'(a_fetch)});
                a_fetch++;
            end
            if (done_a) a_dones++;
        end
    end

    // monitor B: writes must be ascending and carry the image contents
    always @(negedge clk) begin
        if (!rst_b) begin
            if (we_b) begin
                check("b_write", {21'd0, waddr_b, val_b}, {21'd0, 9'(b_writes), entry(b_cfg, b_writes)});
                b_writes++;
            end
            if (done_b) b_dones++;
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 29 + (i >> 5));
        mem[11'h180] = 8'hE4;
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        sel_a = 4'd0; sel_b = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;

        check("rst_src_addr", {21'd0, src_addr_a}, 32'd0);
        check("rst_src_re",   {31'd0, src_re_a},  32'd0);
        check("rst_we",       {31'd0, we_a},      32'd0);
        check("rst_val",      {30'd0, val_a},     32'd0);
        check("rst_waddr",    {23'd0, waddr_a},   32'd0);
        check("rst_busy",     {31'd0, busy_a},    32'd0);
        check("rst_done",     {31'd0, done_a},    32'd0);
        check("rst_hold",     {31'd0, hold_a},    32'd1);
        check("rst_hold_b",   {31'd0, hold_b},    32'd1);

        // no auto-start: stays idle with the CPU held
        rst_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_no_auto", {29'd0, busy_a, hold_a, we_a}, 32'b010);
        end

        // load image 3
        sel_a = 4'd3; start_a = 1'b1; a_cfg = 4'd3; a_fetch = 0;
        push_load(4'd3);
        cyc = 0;
        step();
        start_a = 1'b0;
        check("c1_src_re",   {31'd0, src_re_a}, 32'd1);
        check("c1_src_addr", {21'd0, src_addr_a}, 32'h180);
        check("c1_busy_hold", {30'd0, busy_a, hold_a}, 32'b11);
        step();
        check("c2_src_re", {31'd0, src_re_a}, 32'd0);
        check("c2_we",     {31'd0, we_a},     32'd0);
        step();
        check("c3_write", {20'd0, we_a, waddr_a, val_a}, {20'd0, 1'b1, 9'd0, 2'd0});
        step();
        check("c4_write", {20'd0, we_a, waddr_a, val_a}, {20'd0, 1'b1, 9'd1, 2'd1});

        // start and new config_sel while busy must be ignored
        run_to(100);
        start_a = 1'b1; sel_a = 4'd5;
        step();
        start_a = 1'b0;

        run_to(768);
        check("c768_last_write", {22'd0, we_a, waddr_a}, {22'd0, 1'b1, 9'd511});
        check("c768_count",      32'(a_writes), 32'd512);
        check("c768_hold",       {31'd0, hold_a}, 32'd1);
        step();
        check("c769_done",  {31'd0, done_a}, 32'd1);
        check("c769_hold",  {31'd0, hold_a}, 32'd0);
        check("c769_busy",  {31'd0, busy_a}, 32'd0);
        check("c769_we",    {31'd0, we_a},   32'd0);
        check("c769_ndone", 32'(a_dones),    32'd1);
        check("c769_sb_empty", 32'(exp_q.size()), 32'd0);

        // start in DONE is dropped; held into the next IDLE cycle it is taken
        start_a = 1'b1; sel_a = 4'd7;
        step();
        check("c770_idle", {29'd0, busy_a, done_a, src_re_a}, 32'd0);
        check("c770_hold", {31'd0, hold_a}, 32'd0);
        a_cfg = 4'd7; a_fetch = 0;
        push_load(4'd7);
        step();
        start_a = 1'b0;
        check("c771_fetch", {20'd0, src_re_a, src_addr_a}, {20'd0, 1'b1, 4'd7, 7'd0});
        check("c771_busy_hold", {30'd0, busy_a, hold_a}, 32'b11);
        for (int i = 0; i < 1000 && !done_a; i++) step();
        check("reload_done",   {31'd0, done_a}, 32'd1);
        check("reload_writes", 32'(a_writes), 32'd1024);
        check("reload_ndone",  32'(a_dones), 32'd2);
        check("reload_sb_empty", 32'(exp_q.size()), 32'd0);

        // auto-start instance: starts itself, reset mid-load aborts and restarts
        sel_b = 4'd2; b_cfg = 4'd2; b_writes = 0;
        rst_b = 1'b0;
        cyc = 0;
        step();
        check("b_auto_fetch", {20'd0, src_re_b, src_addr_b}, {20'd0, 1'b1, 4'd2, 7'd0});
        check("b_auto_busy_hold", {30'd0, busy_b, hold_b}, 32'b11);
        run_to(300);
        check("b_c300_writes", 32'(b_writes), 32'd200);
        rst_b = 1'b1;
        step();
        check("b_abort", {29'd0, we_b, busy_b, hold_b}, 32'b001);
        rst_b = 1'b0; sel_b = 4'd9; b_cfg = 4'd9; b_writes = 0;
        step();
        check("b_restart_fetch", {20'd0, src_re_b, src_addr_b}, {20'd0, 1'b1, 4'd9, 7'd0});
        for (int i = 0; i < 1000 && !done_b; i++) step();
        check("b_done",   {31'd0, done_b}, 32'd1);
        check("b_writes", 32'(b_writes), 32'd512);
        check("b_ndone",  32'(b_dones), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
